// File: rtl/mbist_fail_logger.sv
// MBIST fail logger: captures mismatching compares into a first-word-fall-through
// log FIFO, with sticky fail/overflow flags and a saturating mismatch counter.
module mbist_fail_logger #(
  parameter int wcount  = 256,
  parameter int wlength = 4,
  parameter int depth   = 8,
  parameter int cwidth  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      cmp_valid,
  input  logic [$clog2(wcount)-1:0] cmp_addr,
  input  logic [wlength-1:0]        cmp_exp,
  input  logic [wlength-1:0]        cmp_act,
  input  logic                      done,
  input  logic                      log_ready,
  output logic                      log_valid,
  output logic [$clog2(wcount)-1:0] log_addr,
  output logic [wlength-1:0]        log_syn,
  output logic                      fail,
  output logic                      overflow,
  output logic [cwidth-1:0]         fail_count,
  output logic                      busy
);

  localparam int aw = $clog2(wcount);
  localparam int pw = $clog2(depth);
  localparam int ew = aw + wlength;
  localparam logic [pw:0] full_cnt = (pw+1)'(depth);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t            state_r, state_s;
  logic [ew-1:0]     mem_r [depth];
  logic [pw-1:0]     wr_ptr_r, rd_ptr_r;
  logic [pw:0]       count_r;
  logic              fail_r, overflow_r;
  logic [cwidth-1:0] fail_count_r;
  logic              mismatch_s, pop_s, push_s, drop_s, full_s;
  logic [ew-1:0]     head_s;

  function automatic logic [wlength-1:0] syndrome(input logic [wlength-1:0] exp_v,
                                                  input logic [wlength-1:0] act_v);
    return exp_v ^ act_v;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_s;
  end

  // Next-state logic; start re-arms from any state and wins over done
  always_comb begin
    state_s = state_r;
    if (start) begin
      state_s = ARMED;
    end else begin
      case (state_r)
        IDLE:    state_s = IDLE;
        ARMED:   if (done) state_s = DONE; else state_s = ARMED;
        DONE:    state_s = DONE;
        default: state_s = IDLE;
      endcase
    end
  end

  // Event decode; a pop frees the slot so push and pop on a full FIFO both proceed
  always_comb begin
    full_s     = (count_r == full_cnt);
    mismatch_s = 1'b0;
    pop_s      = 1'b0;
    if (!start) begin
      mismatch_s = (state_r == ARMED) && cmp_valid && (cmp_exp != cmp_act);
      pop_s      = (count_r != {(pw+1){1'b0}}) && log_ready;
    end else begin
      mismatch_s = 1'b0;
      pop_s      = 1'b0;
    end
    push_s = mismatch_s && (!full_s || pop_s);
    drop_s = mismatch_s && full_s && !pop_s;
  end

  // Log storage; contents need no reset because the occupancy gates visibility
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= {cmp_addr, syndrome(cmp_exp, cmp_act)};
  end

  // FIFO pointers, occupancy and sticky status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r     <= {pw{1'b0}};
      rd_ptr_r     <= {pw{1'b0}};
      count_r      <= {(pw+1){1'b0}};
      fail_r       <= 1'b0;
      overflow_r   <= 1'b0;
      fail_count_r <= {cwidth{1'b0}};
    end else if (start) begin
      wr_ptr_r     <= {pw{1'b0}};
      rd_ptr_r     <= {pw{1'b0}};
      count_r      <= {(pw+1){1'b0}};
      fail_r       <= 1'b0;
      overflow_r   <= 1'b0;
      fail_count_r <= {cwidth{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + pw'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + pw'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (pw+1)'(1);
        2'b01:   count_r <= count_r - (pw+1)'(1);
        default: count_r <= count_r;
      endcase
      if (mismatch_s) begin
        fail_r <= 1'b1;
        if (fail_count_r != {cwidth{1'b1}}) fail_count_r <= fail_count_r + cwidth'(1);
      end
      if (drop_s) overflow_r <= 1'b1;
    end
  end

  // Head entry presented only while the FIFO holds data
  always_comb begin
    head_s    = mem_r[rd_ptr_r];
    log_valid = (count_r != {(pw+1){1'b0}});
    if (log_valid) begin
      log_addr = head_s[ew-1:wlength];
      log_syn  = head_s[wlength-1:0];
    end else begin
      log_addr = {aw{1'b0}};
      log_syn  = {wlength{1'b0}};
    end
  end

  assign fail       = fail_r;
  assign overflow   = overflow_r;
  assign fail_count = fail_count_r;
  assign busy       = (state_r == ARMED);

endmodule

// File: tb/tb_mbist_fail_logger.sv
// Self-checking bench for mbist_fail_logger: directed vector table plus a
// queue scoreboard of expected log entries and multi-cycle corner sequences.
module tb_mbist_fail_logger;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, cmp_valid = 1'b0, done = 1'b0, log_ready = 1'b0;
  logic [7:0] cmp_addr = 8'h00;
  logic [3:0] cmp_exp = 4'h0, cmp_act = 4'h0;
  logic       log_valid, fail, overflow, busy;
  logic [7:0] log_addr, fail_count;
  logic [3:0] log_syn;

  mbist_fail_logger dut (
    .clk(clk), .rst(rst), .start(start), .cmp_valid(cmp_valid),
    .cmp_addr(cmp_addr), .cmp_exp(cmp_exp), .cmp_act(cmp_act), .done(done),
    .log_ready(log_ready), .log_valid(log_valid), .log_addr(log_addr),
    .log_syn(log_syn), .fail(fail), .overflow(overflow),
    .fail_count(fail_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] addr; logic [3:0] syn; } entry_t;
  typedef struct {
    logic st, vl; logic [7:0] a; logic [3:0] e, ac; logic dn, rd;
    logic x_fail; logic [7:0] x_cnt; logic x_ov, x_lv, x_busy;
  } vec_t;

  entry_t sb[$];
  int     n_vec = 0, n_miss = 0;
  logic   m_fail = 1'b0, m_ov = 1'b0;
  int     m_cnt = 0, m_state = 0;   // 0 idle, 1 armed, 2 done

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    m_fail = 1'b0; m_ov = 1'b0; m_cnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " fail"}, 32'(fail), 32'(m_fail));
    check({tag, " overflow"}, 32'(overflow), 32'(m_ov));
    check({tag, " fail_count"}, 32'(fail_count), 32'(m_cnt));
    check({tag, " busy"}, 32'(busy), 32'(m_state == 1));
    check({tag, " log_valid"}, 32'(log_valid), 32'(sb.size() > 0));
    if (sb.size() > 0) begin
      check({tag, " head addr"}, 32'(log_addr), 32'(sb[0].addr));
      check({tag, " head syn"}, 32'(log_syn), 32'(sb[0].syn));
    end
  endtask

  task automatic step(input logic st, input logic vl, input logic [7:0] a,
                      input logic [3:0] e, input logic [3:0] ac,
                      input logic dn, input logic rd);
    entry_t ent;
    @(negedge clk);
    start = st; cmp_valid = vl; cmp_addr = a; cmp_exp = e; cmp_act = ac;
    done = dn; log_ready = rd;
    if (st) begin
      model_clear();
      m_state = 1;
    end else begin
      if (rd && sb.size() > 0) begin
        ent = sb.pop_front();
        check("pop addr", 32'(log_addr), 32'(ent.addr));
        check("pop syn", 32'(log_syn), 32'(ent.syn));
      end
      if (m_state == 1 && vl && e != ac) begin
        m_fail = 1'b1;
        if (m_cnt < 255) m_cnt++;
        if (sb.size() < 8) sb.push_back('{addr: a, syn: e ^ ac});
        else m_ov = 1'b1;
      end
      if (m_state == 1 && dn) m_state = 2;
    end
    @(posedge clk);
    #1;
    start = 1'b0; cmp_valid = 1'b0; done = 1'b0; log_ready = 1'b0;
    check_outputs("step");
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_clear();
    m_state = 0;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
  endtask

  vec_t tbl[11];
  int   n;

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 8'h05, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 8'h2A, 4'hA, 4'h8, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 8'h03, 4'h5, 4'h5, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 8'h10, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 8'd2, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 8'h11, 4'h1, 4'h2, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 8'd2, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 8'h12, 4'h3, 4'h4, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};

    // reset state
    #12;
    check("rst log_valid", 32'(log_valid), 32'd0);
    check("rst fail_count", 32'(fail_count), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst log_addr", 32'(log_addr), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].st, tbl[i].vl, tbl[i].a, tbl[i].e, tbl[i].ac, tbl[i].dn, tbl[i].rd);
      check($sformatf("tbl%0d fail", i), 32'(fail), 32'(tbl[i].x_fail));
      check($sformatf("tbl%0d fail_count", i), 32'(fail_count), 32'(tbl[i].x_cnt));
      check($sformatf("tbl%0d overflow", i), 32'(overflow), 32'(tbl[i].x_ov));
      check($sformatf("tbl%0d log_valid", i), 32'(log_valid), 32'(tbl[i].x_lv));
      check($sformatf("tbl%0d busy", i), 32'(busy), 32'(tbl[i].x_busy));
      if (i == 2) begin
        check("first miss addr", 32'(log_addr), 32'h2A);
        check("first miss syn", 32'(log_syn), 32'h2);
      end
    end

    // clean run of 256 matching compares
    reset_pulse();
    step(1'b1, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) step(1'b0, 1'b1, 8'(i), 4'(i), 4'(i), 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 1'b1, 1'b0);
    check("clean fail", 32'(fail), 32'd0);
    check("clean fail_count", 32'(fail_count), 32'd0);
    check("clean log_valid", 32'(log_valid), 32'd0);
    check("clean done state", 32'(busy), 32'd0);

    // 10 mismatches with the host stalled, then drain
    step(1'b1, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'(i), 4'hF, 4'(i), 1'b0, 1'b0);
    check("ovf fail_count", 32'(fail_count), 32'd10);
    check("ovf overflow", 32'(overflow), 32'd1);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain addr %0d", k), 32'(log_addr), 32'(k));
      step(1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b1);
    end
    check("drain empty", 32'(log_valid), 32'd0);

    // push and pop on a full FIFO
    step(1'b1, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(8'h20 + i), 4'h0, 4'(i + 1), 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h50, 4'h0, 4'h7, 1'b0, 1'b1);
    check("full pushpop overflow", 32'(overflow), 32'd0);
    check("full pushpop fail_count", 32'(fail_count), 32'd9);
    n = 0;
    while (log_valid && n < 20) begin
      step(1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b1);
      n++;
    end
    check("full pushpop occupancy", 32'(n), 32'd8);

    // counter saturation, then start clears everything
    step(1'b1, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 8'(i), 4'h0, 4'h1, 1'b0, 1'b0);
    check("sat fail_count", 32'(fail_count), 32'd255);
    step(1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0);
    check("sat hold", 32'(fail_count), 32'd255);
    step(1'b1, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0);
    check("restart fail_count", 32'(fail_count), 32'd0);
    check("restart log_valid", 32'(log_valid), 32'd0);
    check("restart overflow", 32'(overflow), 32'd0);

    // asynchronous reset mid-run with entries queued
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(8'h40 + i), 4'h3, 4'h0, 1'b0, 1'b0);
    check("pre-reset log_valid", 32'(log_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    model_clear();
    m_state = 0;
    check("async log_valid", 32'(log_valid), 32'd0);
    check("async fail", 32'(fail), 32'd0);
    check("async fail_count", 32'(fail_count), 32'd0);
    check("async busy", 32'(busy), 32'd0);
    check("async log_addr", 32'(log_addr), 32'd0);
    check("async log_syn", 32'(log_syn), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b1, 8'h33, 4'h1, 4'h0, 1'b0, 1'b0);
    check("post-reset ignored", 32'(fail), 32'd0);
    check("post-reset idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
